// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
//   rx_state_t   : receiver FSM states
//   PARITY_*     : encodings of the PARITY parameter
//   cnt_width()  : width of a counter that must hold 0..n-1
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for a single asynchronous input bit.
//   clk, rst : system clock, asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronised output (2-cycle latency)
// RESET_VAL sets the level both flops take in reset, so an idle-high line
// does not look like an edge when reset is released.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver (DATA_BITS, PARITY, STOP_BITS)
// with input synchroniser, parity / framing error detection, a valid/ready
// holding register and overrun reporting.
//   clk, rst      : system clock, asynchronous active-high reset
//   i_rx          : serial line, asynchronous, idle high
//   o_data        : received word (LSB arrives first)
//   o_valid       : o_data and error flags valid
//   i_ready       : consumer accepts the word when o_valid & i_ready
//   o_parity_err  : parity mismatch on the held word (0 when PARITY = 0)
//   o_frame_err   : a stop bit was sampled low on the held word
//   o_overrun     : one-cycle pulse, a completed frame was dropped
//   o_busy        : receiver not in IDLE
// Build option: define UART_RX_MAJORITY_EN to take a 2-of-3 vote of the
// synchronised line around every sample point (adds one cycle of latency).
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 87,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int              CW        = cnt_width(CLK_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_MID   = CW'((CLK_PER_BIT - 1) / 2);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

    // FSM state is a named signal so checkers can bind to it directly.
    rx_state_t              state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [3:0]             bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n, data_n;
    logic                   par_acc, par_acc_n, frm_acc, frm_acc_n;
    logic                   valid_n, perr_n, ferr_n, overrun_n, busy_n;
    logic                   frame_bad, complete;
    logic                   rx_s, rx_bit;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (i_rx),
        .q   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Voting over three consecutive rx_s values delays every decision by one
    // cycle: the FSM sees the vote of target-1..target+1 at its usual count.
    logic rx_d1, rx_d2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    assign rx_bit = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
    assign rx_bit = rx_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_acc      <= 1'b0;
            frm_acc      <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_cnt      <= bit_cnt_n;
            shreg        <= shreg_n;
            par_acc      <= par_acc_n;
            frm_acc      <= frm_acc_n;
            o_data       <= data_n;
            o_valid      <= valid_n;
            o_parity_err <= perr_n;
            o_frame_err  <= ferr_n;
            o_overrun    <= overrun_n;
            o_busy       <= busy_n;
        end
    end

    // Handshake: a word transfers on any cycle with o_valid & i_ready high.
    // o_valid then drops on the following cycle unless a frame completes in
    // that same cycle, in which case the new word is loaded and o_valid stays
    // high. Held data and flags never change while o_valid is high and no
    // transfer occurs; a completion in that situation is dropped and reported
    // on o_overrun.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_acc_n = par_acc;
        frm_acc_n = frm_acc;
        data_n    = o_data;
        valid_n   = o_valid;
        perr_n    = o_parity_err;
        ferr_n    = o_frame_err;
        overrun_n = 1'b0;
        frame_bad = frm_acc;
        complete  = 1'b0;

        if (o_valid && i_ready) begin
            valid_n = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (!rx_bit) begin
                    state_n   = ST_START;
                    bit_cnt_n = '0;
                    par_acc_n = 1'b0;
                    frm_acc_n = 1'b0;
                end
            end
            ST_START: begin
                if (cnt == CNT_MID) begin
                    cnt_n   = '0;
                    state_n = rx_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_bit, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_STOP;
                    // XOR over data plus parity bit must be 1 for odd, 0 for even.
                    par_acc_n = (PARITY == PARITY_ODD) ? ~(^shreg ^ rx_bit)
                                                       :  (^shreg ^ rx_bit);
                end
            end
            ST_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    frame_bad = frm_acc | ~rx_bit;
                    frm_acc_n = frame_bad;
                    if (bit_cnt == STOP_LAST) begin
                        complete = 1'b1;
                        // A bad stop bit usually means a held-low line; wait
                        // for it to return high before hunting for a start bit.
                        state_n  = frame_bad ? ST_BREAK : ST_IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
            end
            ST_BREAK: begin
                cnt_n = '0;
                if (rx_bit) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase

        if (complete) begin
            if (!o_valid || i_ready) begin
                data_n  = shreg;
                perr_n  = par_acc;
                ferr_n  = frame_bad;
                valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end

        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench for uart_rx_frame.
// Two instances share clk/rst: dut8 is 8N1, dut7 is 7 data bits, even
// parity, 2 stop bits. Both run at CLK_PER_BIT = 87 with a 100 ns clock.
// Inputs change 1 ns after a rising edge; outputs are observed on the
// falling edge by a monitor that records accepted words and event times.
module tb_uart_rx_frame;

    localparam int CPB = 87;
    localparam int MID = (CPB - 1) / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #50 clk = ~clk;

    logic       rx8, rdy8, v8, pe8, fe8, ov8, bz8;
    logic [7:0] d8;
    logic       rx7, rdy7, v7, pe7, fe7, ov7, bz7;
    logic [6:0] d7;

    uart_rx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8 (
        .clk(clk), .rst(rst), .i_rx(rx8), .o_data(d8), .o_valid(v8), .i_ready(rdy8),
        .o_parity_err(pe8), .o_frame_err(fe8), .o_overrun(ov8), .o_busy(bz8)
    );

    uart_rx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut7 (
        .clk(clk), .rst(rst), .i_rx(rx7), .o_data(d7), .o_valid(v7), .i_ready(rdy7),
        .o_parity_err(pe7), .o_frame_err(fe7), .o_overrun(ov7), .o_busy(bz7)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int lat     = 10 * CPB - MID + 4;

    // Monitor: accepted words packed as {parity_err, frame_err, 9-bit data}.
    int          cyc = 0;
    int          vcyc8 = 0, ovr8 = 0, rise8 = 0, bz_rise8 = 0, bz_fall8 = 0, vcyc7 = 0;
    logic        v8_q = 1'b0, bz8_q = 1'b0;
    logic [10:0] acc_q8[$];
    logic [10:0] acc_q7[$];

    always @(negedge clk) begin
        cyc   <= cyc + 1;
        v8_q  <= v8;
        bz8_q <= bz8;
        if (v8 && !v8_q) rise8 <= cyc + 1;
        if (bz8 && !bz8_q) bz_rise8 <= cyc + 1;
        if (!bz8 && bz8_q) bz_fall8 <= cyc + 1;
        if (v8) vcyc8 <= vcyc8 + 1;
        if (v7) vcyc7 <= vcyc7 + 1;
        if (ov8) ovr8 <= ovr8 + 1;
        if (v8 && rdy8) acc_q8.push_back({pe8, fe8, 1'b0, d8});
        if (v7 && rdy7) acc_q7.push_back({pe7, fe7, 2'b00, d7});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // which = 0 drives dut8 (8N1), which = 1 drives dut7 (7E2).
    task automatic send_frame(input int which, input logic [8:0] d, input bit par_flip);
        logic bits[$];
        int   nb;
        int   ns;
        nb = (which == 0) ? 8 : 7;
        ns = (which == 0) ? 1 : 2;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(d[i]);
        if (which == 1) bits.push_back((^d[6:0]) ^ par_flip);
        for (int i = 0; i < ns; i++) bits.push_back(1'b1);
        foreach (bits[i]) begin
            if (which == 0) rx8 = bits[i];
            else            rx7 = bits[i];
            tick(CPB);
        end
    endtask

    task automatic test_reset();
        vec_cnt++;
        if ({d8, v8, pe8, fe8, ov8, bz8} !== 13'h0) begin
            err_cnt++;
            $display("FAIL reset_dut8: got %h expected 0", {d8, v8, pe8, fe8, ov8, bz8});
        end
        vec_cnt++;
        if ({d7, v7, pe7, fe7, ov7, bz7} !== 12'h0) begin
            err_cnt++;
            $display("FAIL reset_dut7: got %h expected 0", {d7, v7, pe7, fe7, ov7, bz7});
        end
    endtask

    task automatic test_baseline_8n1();
        int          t0, vc;
        logic [10:0] w;
        rdy8 = 1'b1;
        acc_q8.delete();
        vc = vcyc8;
        t0 = cyc;
        send_frame(0, 9'h0AB, 1'b0);
        tick(CPB);
        w = 11'h7FF;
        if (acc_q8.size() > 0) w = acc_q8.pop_front();
        vec_cnt++;
        if (w !== 11'h0AB) begin
            err_cnt++;
            $display("FAIL base_word: got %h expected %h", w, 11'h0AB);
        end
        vec_cnt++;
        if (acc_q8.size() !== 0) begin
            err_cnt++;
            $display("FAIL base_extra_words: got %0d expected 0", acc_q8.size());
        end
        vec_cnt++;
        if ((vcyc8 - vc) !== 1) begin
            err_cnt++;
            $display("FAIL base_valid_cycles: got %0d expected 1", vcyc8 - vc);
        end
        // o_valid should rise roughly half a bit before the end of the stop bit.
        lat = rise8 - t0;
        vec_cnt++;
        if (lat < 10 * CPB - MID - 10 || lat > 10 * CPB - MID + 10) begin
            err_cnt++;
            $display("FAIL base_latency: got %0d expected %0d..%0d", lat,
                     10 * CPB - MID - 10, 10 * CPB - MID + 10);
            lat = 10 * CPB - MID + 4;
        end
    endtask

    task automatic test_parity_7e2();
        logic [10:0] w;
        rdy7 = 1'b1;
        acc_q7.delete();
        send_frame(1, 9'h055, 1'b0);
        tick(CPB);
        w = 11'h7FF;
        if (acc_q7.size() > 0) w = acc_q7.pop_front();
        vec_cnt++;
        if (w !== 11'h055) begin
            err_cnt++;
            $display("FAIL par_good_word: got %h expected %h", w, 11'h055);
        end
        send_frame(1, 9'h055, 1'b1);
        tick(CPB);
        w = 11'h7FF;
        if (acc_q7.size() > 0) w = acc_q7.pop_front();
        vec_cnt++;
        if (w !== 11'h455) begin
            err_cnt++;
            $display("FAIL par_bad_word: got %h expected %h", w, 11'h455);
        end
        vec_cnt++;
        if (vcyc7 !== 2) begin
            err_cnt++;
            $display("FAIL par_valid_cycles: got %0d expected 2", vcyc7);
        end
    endtask

    task automatic test_glitch();
        int t0, vc;
        rdy8 = 1'b1;
        acc_q8.delete();
        vc = vcyc8;
        t0 = cyc;
        rx8 = 1'b0;
        tick(20);
        rx8 = 1'b1;
        tick(3 * CPB);
        vec_cnt++;
        if (bz_rise8 <= t0) begin
            err_cnt++;
            $display("FAIL glitch_busy_seen: got rise at %0d expected after %0d", bz_rise8, t0);
        end
        vec_cnt++;
        if ((bz_fall8 - bz_rise8) > MID + 3 || bz_fall8 <= bz_rise8) begin
            err_cnt++;
            $display("FAIL glitch_busy_len: got %0d expected 1..%0d", bz_fall8 - bz_rise8, MID + 3);
        end
        vec_cnt++;
        if (bz8 !== 1'b0) begin
            err_cnt++;
            $display("FAIL glitch_idle: got busy %b expected 0", bz8);
        end
        vec_cnt++;
        if ((vcyc8 - vc) !== 0 || acc_q8.size() !== 0) begin
            err_cnt++;
            $display("FAIL glitch_no_word: got %0d valid cycles expected 0", vcyc8 - vc);
        end
    endtask

    task automatic test_break();
        int          vc;
        logic [10:0] w;
        rdy8 = 1'b1;
        acc_q8.delete();
        vc = vcyc8;
        rx8 = 1'b0;
        tick(30 * CPB);
        vec_cnt++;
        if ((vcyc8 - vc) !== 1) begin
            err_cnt++;
            $display("FAIL break_valid_cycles: got %0d expected 1", vcyc8 - vc);
        end
        w = 11'h7FF;
        if (acc_q8.size() > 0) w = acc_q8.pop_front();
        vec_cnt++;
        if (w !== 11'h200) begin
            err_cnt++;
            $display("FAIL break_word: got %h expected %h", w, 11'h200);
        end
        vec_cnt++;
        if (bz8 !== 1'b1) begin
            err_cnt++;
            $display("FAIL break_busy_low_line: got %b expected 1", bz8);
        end
        rx8 = 1'b1;
        tick(CPB + 5);
        vec_cnt++;
        if ((vcyc8 - vc) !== 1 || bz8 !== 1'b0) begin
            err_cnt++;
            $display("FAIL break_release: got valid cycles %0d busy %b expected 1 0", vcyc8 - vc, bz8);
        end
        send_frame(0, 9'h05A, 1'b0);
        tick(CPB);
        w = 11'h7FF;
        if (acc_q8.size() > 0) w = acc_q8.pop_front();
        vec_cnt++;
        if (w !== 11'h05A) begin
            err_cnt++;
            $display("FAIL break_next_word: got %h expected %h", w, 11'h05A);
        end
    endtask

    task automatic test_overrun();
        int          o0;
        logic [10:0] w;
        rdy8 = 1'b0;
        acc_q8.delete();
        o0 = ovr8;
        send_frame(0, 9'h012, 1'b0);
        tick(CPB);
        send_frame(0, 9'h034, 1'b0);
        tick(CPB);
        vec_cnt++;
        if (v8 !== 1'b1 || d8 !== 8'h12) begin
            err_cnt++;
            $display("FAIL ovr_held: got valid %b data %h expected 1 12", v8, d8);
        end
        vec_cnt++;
        if ((ovr8 - o0) !== 1) begin
            err_cnt++;
            $display("FAIL ovr_pulses: got %0d expected 1", ovr8 - o0);
        end
        rdy8 = 1'b1;
        tick(2);
        rdy8 = 1'b0;
        w = 11'h7FF;
        if (acc_q8.size() > 0) w = acc_q8.pop_front();
        vec_cnt++;
        if (w !== 11'h012 || v8 !== 1'b0) begin
            err_cnt++;
            $display("FAIL ovr_drain: got word %h valid %b expected 012 0", w, v8);
        end

        // Second pass: accept the held word in exactly the completion cycle
        // of the next frame, using the latency measured on the baseline frame.
        send_frame(0, 9'h012, 1'b0);
        tick(CPB);
        o0 = ovr8;
        fork
            send_frame(0, 9'h034, 1'b0);
            begin
                tick(lat - 2);
                rdy8 = 1'b1;
                tick(1);
                rdy8 = 1'b0;
            end
        join
        tick(CPB);
        vec_cnt++;
        if (v8 !== 1'b1 || d8 !== 8'h34) begin
            err_cnt++;
            $display("FAIL same_cycle_load: got valid %b data %h expected 1 34", v8, d8);
        end
        vec_cnt++;
        if ((ovr8 - o0) !== 0) begin
            err_cnt++;
            $display("FAIL same_cycle_overrun: got %0d expected 0", ovr8 - o0);
        end
        w = 11'h7FF;
        if (acc_q8.size() > 0) w = acc_q8.pop_front();
        vec_cnt++;
        if (w !== 11'h012) begin
            err_cnt++;
            $display("FAIL same_cycle_first: got %h expected %h", w, 11'h012);
        end
        rdy8 = 1'b1;
        tick(2);
        w = 11'h7FF;
        if (acc_q8.size() > 0) w = acc_q8.pop_front();
        vec_cnt++;
        if (w !== 11'h034) begin
            err_cnt++;
            $display("FAIL same_cycle_second: got %h expected %h", w, 11'h034);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  c3;
        logic [10:0] w;
        int          g;
        c3   = 8'hC3;
        rdy8 = 1'b0;
        send_frame(0, 9'h077, 1'b0);
        tick(CPB);
        rx8 = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx8 = c3[i];
            tick(CPB);
        end
        rx8 = c3[4];
        tick(CPB / 2);
        vec_cnt++;
        if (bz8 !== 1'b1 || v8 !== 1'b1) begin
            err_cnt++;
            $display("FAIL midframe_pre: got busy %b valid %b expected 1 1", bz8, v8);
        end
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({d8, v8, pe8, fe8, ov8, bz8} !== 13'h0) begin
            err_cnt++;
            $display("FAIL midframe_reset: got %h expected 0", {d8, v8, pe8, fe8, ov8, bz8});
        end
        rx8 = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(CPB);
        rdy8 = 1'b1;
        acc_q8.delete();
        // One-cycle low glitch inside data bit 2 of 0x3C. The majority build
        // gets it on the exact sample edge; the single-sample build gets it
        // clear of the sample edge.
`ifdef UART_RX_MAJORITY_EN
        g = 2 + MID + 3 * CPB;
`else
        g = 2 + MID + 3 * CPB + 10;
`endif
        fork
            send_frame(0, 9'h03C, 1'b0);
            begin
                tick(g - 1);
                rx8 = ~rx8;
                tick(1);
                rx8 = ~rx8;
            end
        join
        tick(CPB);
        w = 11'h7FF;
        if (acc_q8.size() > 0) w = acc_q8.pop_front();
        vec_cnt++;
        if (w !== 11'h03C) begin
            err_cnt++;
            $display("FAIL midframe_next_word: got %h expected %h", w, 11'h03C);
        end
    endtask

    initial begin
        rx8  = 1'b1;
        rx7  = 1'b1;
        rdy8 = 1'b0;
        rdy7 = 1'b0;
        rst  = 1'b1;
        tick(3);
        test_reset();
        rst = 1'b0;
        tick(5);
        test_baseline_8n1();
        test_parity_7e2();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
